vx_mem_tag_remap: RTL

VX_MEM_TAG_REMAP -- requirements
Module: VX_mem_tag_remap

---
 rtl/vx_mem_tag_remap.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vx_mem_tag_remap.sv
// Memory tag remapper. Sits between a cache memory port and the memory system.
// Wide upstream read tags are parked in a small slot table, and the slot index
// is sent downstream instead. Responses look up the original tag by slot index
// and come back through a one-entry registered buffer. Writes carry no tag and
// bypass the slot table.
module vx_mem_tag_remap #(
    parameter int DATA_SIZE     = 64,
    parameter int ADDR_WIDTH    = 26,
    parameter int IN_TAG_WIDTH  = 12,
    parameter int OUT_TAG_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       in_req_valid,
    input  logic                       in_req_rw,
    input  logic [ADDR_WIDTH-1:0]      in_req_addr,
    input  logic [8*DATA_SIZE-1:0]     in_req_data,
    input  logic [DATA_SIZE-1:0]       in_req_byteen,
    input  logic [IN_TAG_WIDTH-1:0]    in_req_tag,
    output logic                       in_req_ready,

    output logic                       out_req_valid,
    output logic                       out_req_rw,
    output logic [ADDR_WIDTH-1:0]      out_req_addr,
    output logic [8*DATA_SIZE-1:0]     out_req_data,
    output logic [DATA_SIZE-1:0]       out_req_byteen,
    output logic [OUT_TAG_WIDTH-1:0]   out_req_tag,
    input  logic                       out_req_ready,

    input  logic                       out_rsp_valid,
    input  logic [8*DATA_SIZE-1:0]     out_rsp_data,
    input  logic [OUT_TAG_WIDTH-1:0]   out_rsp_tag,
    output logic                       out_rsp_ready,

    output logic                       in_rsp_valid,
    output logic [8*DATA_SIZE-1:0]     in_rsp_data,
    output logic [IN_TAG_WIDTH-1:0]    in_rsp_tag,
    input  logic                       in_rsp_ready,

    output logic [OUT_TAG_WIDTH:0]     pending,
    output logic                       full,
    output logic                       empty,
    output logic                       tag_err
);

    localparam int N      = 1 << OUT_TAG_WIDTH;
    localparam int DATA_W = 8 * DATA_SIZE;
    localparam logic [OUT_TAG_WIDTH:0] SLOT_CNT = (OUT_TAG_WIDTH+1)'(N);
    localparam logic [OUT_TAG_WIDTH:0] CNT_ONE  = {{OUT_TAG_WIDTH{1'b0}}, 1'b1};

    logic [N-1:0]              alloc_mask;
    logic [N-1:0]              alloc_set;
    logic [N-1:0]              alloc_clr;
    logic [OUT_TAG_WIDTH:0]    pending_q;
    logic [IN_TAG_WIDTH-1:0]   tag_mem [N];
    logic [OUT_TAG_WIDTH-1:0]  free_idx;
    logic                      alloc_fire;
    logic                      rsp_fire;
    logic                      rsp_hit;
    logic                      rsp_miss;
    logic                      tag_err_q;
    logic                      rsp_vld_p1;
    logic [DATA_W-1:0]         rsp_data_p1;
    logic [IN_TAG_WIDTH-1:0]   rsp_tag_p1;

    // Lowest-index slot whose allocated bit is clear; 0 when nothing is free
    // (the request is blocked by full in that case, so the value is unused).
    function automatic logic [OUT_TAG_WIDTH-1:0] lowest_free(input logic [N-1:0] mask);
        lowest_free = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!mask[i]) lowest_free = OUT_TAG_WIDTH'(i);
        end
    endfunction

    // Saturating occupancy update: never past N, never below 0; a
    // simultaneous allocate and free leave the count unchanged.
    function automatic logic [OUT_TAG_WIDTH:0] pend_update(
        input logic [OUT_TAG_WIDTH:0] cnt,
        input logic                   inc,
        input logic                   dec
    );
        pend_update = cnt;
        if (inc && !dec && cnt != SLOT_CNT) pend_update = cnt + CNT_ONE;
        if (dec && !inc && cnt != '0)       pend_update = cnt - CNT_ONE;
    endfunction

    assign pending = pending_q;
    assign full    = (pending_q == SLOT_CNT);
    assign empty   = (pending_q == '0);
    assign tag_err = tag_err_q;

    // Stage 0: combinational request path; reads stall only when no slot is free
    assign in_req_ready   = out_req_ready && (in_req_rw || !full);
    assign out_req_valid  = in_req_valid && (in_req_rw || !full);
    assign out_req_rw     = in_req_rw;
    assign out_req_addr   = in_req_addr;
    assign out_req_data   = in_req_data;
    assign out_req_byteen = in_req_byteen;
    assign free_idx       = lowest_free(alloc_mask);
    assign out_req_tag    = in_req_rw ? '0 : free_idx;
    assign alloc_fire     = in_req_valid && in_req_ready && !in_req_rw;

    assign out_rsp_ready = !rsp_vld_p1 || in_rsp_ready;
    assign rsp_fire      = out_rsp_valid && out_rsp_ready;
    assign rsp_hit       = rsp_fire && alloc_mask[out_rsp_tag];
    assign rsp_miss      = rsp_fire && !alloc_mask[out_rsp_tag];

    // Slot set/clear vectors; allocation picks from the pre-update mask so a
    // slot freed this cycle cannot be handed out again in the same cycle.
    always_comb begin
        alloc_set = '0;
        alloc_clr = '0;
        if (alloc_fire) alloc_set[free_idx]    = 1'b1;
        if (rsp_hit)    alloc_clr[out_rsp_tag] = 1'b1;
    end

    // Control state: slot mask, occupancy, sticky error and buffer valid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_mask <= '0;
            pending_q  <= '0;
            tag_err_q  <= 1'b0;
            rsp_vld_p1 <= 1'b0;
        end else begin
            alloc_mask <= (alloc_mask | alloc_set) & ~alloc_clr;
            pending_q  <= pend_update(pending_q, alloc_fire, rsp_hit);
            if (rsp_miss) tag_err_q <= 1'b1;
            if (rsp_hit)
                rsp_vld_p1 <= 1'b1;
            else if (in_rsp_ready)
                rsp_vld_p1 <= 1'b0;
        end
    end

    // Upstream tag capture for each newly allocated slot
    always_ff @(posedge clk) begin
        if (alloc_fire) tag_mem[free_idx] <= in_req_tag;
    end

    // Stage 1: response buffer payload, loaded only by a valid-slot response
    always_ff @(posedge clk) begin
        if (rsp_hit) begin
            rsp_data_p1 <= out_rsp_data;
            rsp_tag_p1  <= tag_mem[out_rsp_tag];
        end
    end

    assign in_rsp_valid = rsp_vld_p1;
    assign in_rsp_data  = rsp_data_p1;
    assign in_rsp_tag   = rsp_tag_p1;

endmodule
